// File: rtl/async_fifo_pkg.sv
// Shared async-FIFO package: default geometry plus the Gray-code helpers used
// by both the write-side and read-side pointer logic.
// Ports: none (package).
package async_fifo_pkg;

   localparam int unsigned FIFO_DEPTH      = 16;
   localparam int unsigned FIFO_ADDR_WIDTH = 4;

   // Helpers work on a fixed wide vector; callers cast to and from their pointer width.
   // Zero-extended inputs are safe because high zero bits stay zero in either direction.
   localparam int unsigned GRAY_FN_W = 32;

   // Binary to reflected Gray code.
   function automatic logic [GRAY_FN_W-1:0] gray_encode(input logic [GRAY_FN_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Gray to binary: MSB copied, each lower bit XORed with the converted bit above it.
   function automatic logic [GRAY_FN_W-1:0] gray_to_bin(input logic [GRAY_FN_W-1:0] gray);
      logic [GRAY_FN_W-1:0] bin;
      bin = '0;
      bin[GRAY_FN_W-1] = gray[GRAY_FN_W-1];
      for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
         bin[i] = gray[i] ^ bin[i+1];
      end
      return bin;
   endfunction

endpackage

// File: rtl/async_write_full_ctrl_if.sv
// Write-side control bus of the async FIFO.
// Signals: wr_req (producer request), rd_gray_ptr (read-domain Gray pointer),
//          write_en (accepted write), full, almost_full, wr_level, wr_overflow.
// master: producer / read-pointer source.  slave: async_write_full_ctrl.
interface async_write_full_ctrl_if
   import async_fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
);

   logic                  wr_req;
   logic [ADDR_WIDTH:0]   rd_gray_ptr;
   logic                  write_en;
   logic                  full;
   logic                  almost_full;
   logic [ADDR_WIDTH:0]   wr_level;
   logic                  wr_overflow;

   modport master (
      output wr_req, rd_gray_ptr,
      input  write_en, full, almost_full, wr_level, wr_overflow
   );

   modport slave (
      input  wr_req, rd_gray_ptr,
      output write_en, full, almost_full, wr_level, wr_overflow
   );

endinterface

// File: rtl/gray_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the clk domain.
// Ports: clk, reset (async, active-high), d_i (foreign-domain pointer),
//        q_o (synchronized pointer, second flop).
module gray_ptr_sync #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] rq1_q;
   logic [WIDTH-1:0] rq2_q;

   // Plain flop chain; only one bit of a Gray pointer changes per step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rq1_q <= '0;
         rq2_q <= '0;
      end else begin
         rq1_q <= d_i;
         rq2_q <= rq1_q;
      end
   end

   assign q_o = rq2_q;

endmodule

// File: rtl/async_write_full_ctrl.sv
// Write-domain full/level controller of an asynchronous FIFO.
// Ports: wr_clk, reset (async, active-high), bus (slave modport):
//        wr_req in, rd_gray_ptr in, write_en out (combinational),
//        full / almost_full / wr_level out (registered), wr_overflow out.
// Macro WR_OVERFLOW_FLAG_EN: when defined, wr_overflow is a sticky flag set by a
// request against a full FIFO; when undefined it is tied to 0.
module async_write_full_ctrl
   import async_fifo_pkg::*;
#(
   parameter int unsigned DEPTH      = FIFO_DEPTH,
   parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
   parameter int unsigned AF_SLOTS   = 2
) (
   input  logic                  wr_clk,
   input  logic                  reset,
   async_write_full_ctrl_if.slave bus
);

   localparam int unsigned PW = ADDR_WIDTH + 1;
   // Full when the write Gray pointer equals the read one with its top two bits inverted.
   localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

   logic [PW-1:0] wbin_q;
   logic [PW-1:0] wbin_d;
   logic [PW-1:0] rq2_s;
   logic [PW-1:0] rbin_s;
   logic [PW-1:0] level_q;
   logic [PW-1:0] level_d;
   logic          full_q;
   logic          full_d;
   logic          af_q;
   logic          af_d;
   logic          write_en_c;

   assign write_en_c   = bus.wr_req & ~full_q;
   assign bus.write_en = write_en_c;

   gray_ptr_sync #(
      .WIDTH (PW)
   ) u_rd_sync (
      .clk   (wr_clk),
      .reset (reset),
      .d_i   (bus.rd_gray_ptr),
      .q_o   (rq2_s)
   );

   // Next-state pointer and flags; all derived from the post-write pointer.
   always_comb begin
      wbin_d  = wbin_q + PW'(write_en_c);
      rbin_s  = PW'(gray_to_bin(GRAY_FN_W'(rq2_s)));
      full_d  = (PW'(gray_encode(GRAY_FN_W'(wbin_d))) == (rq2_s ^ FULL_MASK));
      level_d = wbin_d - rbin_s;
      af_d    = ((PW'(DEPTH) - level_d) <= PW'(AF_SLOTS));
   end

   // Pointer and status registers.
   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         wbin_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         level_q <= level_d;
         full_q  <= full_d;
         af_q    <= af_d;
      end
   end

   assign bus.full        = full_q;
   assign bus.almost_full = af_q;
   assign bus.wr_level    = level_q;

`ifdef WR_OVERFLOW_FLAG_EN
   logic ovf_q;

   // Sticky until reset.
   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (bus.wr_req && full_q) begin
         ovf_q <= 1'b1;
      end
   end

   assign bus.wr_overflow = ovf_q;
`else
   assign bus.wr_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_async_write_full_ctrl.sv
// Self-checking bench for async_write_full_ctrl: directed scenarios plus
// randomized traffic against a count-based FIFO occupancy model.
module tb_async_write_full_ctrl;

   localparam int DEPTH = 16;

   logic       wr_clk = 1'b0;
   logic       reset;
   logic       wr_req;
   int         rd_count;
   logic [4:0] rd_bin;
   logic [4:0] rd_gray;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: total accepted writes, read count as seen after synchronization delay.
   int m_wr;
   int h1;
   int h2;
   int m_level;
   bit m_full;
   bit m_af;
   bit m_af2;
   bit m_ovf;

   always #5 wr_clk = ~wr_clk;

   assign rd_bin  = 5'(rd_count);
   assign rd_gray = rd_bin ^ (rd_bin >> 1);

   async_write_full_ctrl_if #(.ADDR_WIDTH(4)) bus ();
   async_write_full_ctrl_if #(.ADDR_WIDTH(4)) bus2 ();

   assign bus.wr_req       = wr_req;
   assign bus.rd_gray_ptr  = rd_gray;
   assign bus2.wr_req      = wr_req;
   assign bus2.rd_gray_ptr = rd_gray;

   async_write_full_ctrl #(.DEPTH(16), .ADDR_WIDTH(4), .AF_SLOTS(2)) dut (
      .wr_clk (wr_clk),
      .reset  (reset),
      .bus    (bus)
   );

   async_write_full_ctrl #(.DEPTH(16), .ADDR_WIDTH(4), .AF_SLOTS(4)) dut_af4 (
      .wr_clk (wr_clk),
      .reset  (reset),
      .bus    (bus2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_wr = 0; h1 = 0; h2 = 0; m_level = 0;
      m_full = 0; m_af = 0; m_af2 = 0; m_ovf = 0;
   endtask

   // Advance one clock edge and update the model from the inputs seen at that edge.
   task automatic tick();
      int vis;
      @(posedge wr_clk);
      if (!reset) begin
`ifdef WR_OVERFLOW_FLAG_EN
         if (wr_req && m_full) m_ovf = 1;
`endif
         if (wr_req && !m_full) m_wr++;
         vis = h2;
         h2  = h1;
         h1  = rd_count;
         m_level = m_wr - vis;
         m_full  = (m_level == DEPTH);
         m_af    = ((DEPTH - m_level) <= 2);
         m_af2   = ((DEPTH - m_level) <= 4);
      end
      #1;
   endtask

   // One-cycle reset pulse with immediate check that all outputs cleared.
   task automatic do_reset();
      reset    = 1'b1;
      wr_req   = 1'b0;
      rd_count = 0;
      model_clear();
      #1;
      chk("rst_full",   32'(bus.full),        0);
      chk("rst_af",     32'(bus.almost_full), 0);
      chk("rst_level",  32'(bus.wr_level),    0);
      chk("rst_ovf",    32'(bus.wr_overflow), 0);
      chk("rst_we",     32'(bus.write_en),    0);
      chk("rst_af4",    32'(bus2.almost_full),0);
      tick();
      reset = 1'b0;
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge wr_clk) begin
      chk("write_en",    32'(bus.write_en),    32'(wr_req & ~m_full));
      chk("full",        32'(bus.full),        32'(m_full));
      chk("almost_full", 32'(bus.almost_full), 32'(m_af));
      chk("wr_level",    32'(bus.wr_level),    32'(m_level));
      chk("wr_overflow", 32'(bus.wr_overflow), 32'(m_ovf));
      chk("af4",         32'(bus2.almost_full),32'(m_af2));
      chk("af4_full",    32'(bus2.full),       32'(m_full));
   end

   int wp[6] = '{80, 20, 95, 50, 60, 30};
   int rp[6] = '{30, 80, 10, 50, 55, 70};

   initial begin
      reset    = 1'b1;
      wr_req   = 1'b0;
      rd_count = 0;
      model_clear();
      tick();
      tick();
      reset = 1'b0;

      // Fill from empty with the read pointer parked at 0.
      do_reset();
      wr_req = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("fill_level", 32'(bus.wr_level),    32'(i));
         chk("fill_full",  32'(bus.full),        32'(i == 16));
         chk("fill_af",    32'(bus.almost_full), 32'(i >= 14));
         if (i == 11) chk("af4_at11", 32'(bus2.almost_full), 0);
         if (i == 12) chk("af4_at12", 32'(bus2.almost_full), 1);
      end

      // Requests against a full FIFO are refused.
      for (int i = 0; i < 3; i++) begin
         chk("full_we", 32'(bus.write_en), 0);
         tick();
         chk("full_level", 32'(bus.wr_level), 16);
`ifdef WR_OVERFLOW_FLAG_EN
         chk("ovf_set", 32'(bus.wr_overflow), 1);
`else
         chk("ovf_off", 32'(bus.wr_overflow), 0);
`endif
      end

      // One read frees a slot only after the synchronizer delay.
      wr_req   = 1'b0;
      rd_count = 1;
      tick();
      chk("rd_early_full", 32'(bus.full), 1);
      tick();
      tick();
      chk("rd_late_full",  32'(bus.full),     0);
      chk("rd_late_level", 32'(bus.wr_level), 15);

      // Streaming with reads trailing, pointers wrap past 31.
      do_reset();
      for (int c = 0; c < 44; c++) begin
         wr_req   = 1'b1;
         rd_count = (m_wr >= 3) ? m_wr - 3 : 0;
         tick();
         chk("stream_nofull", 32'(bus.full), 0);
         if (c >= 10)
            chk("stream_band", 32'(bus.wr_level >= 5'd4 && bus.wr_level <= 5'd6), 1);
      end

      // Reset in the middle of operation.
      do_reset();
      wr_req = 1'b1;
      repeat (9) tick();
      chk("pre_rst_level", 32'(bus.wr_level), 9);
      do_reset();
      wr_req = 1'b1;
      #1;
      chk("post_rst_we", 32'(bus.write_en), 1);
      tick();
      chk("post_rst_level", 32'(bus.wr_level), 1);

      // Randomized traffic in phases biased toward full and toward empty.
      do_reset();
      for (int ph = 0; ph < 6; ph++) begin
         for (int c = 0; c < 500; c++) begin
            wr_req = ($urandom_range(99) < 32'(wp[ph]));
            if (rd_count < m_wr && $urandom_range(99) < 32'(rp[ph])) rd_count++;
            if ($urandom_range(999) == 0) do_reset();
            else tick();
         end
      end

      @(posedge wr_clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
